// File: rtl/dmem_responder_if.sv
// Purpose : M-stage data-memory request/response bundle between the core and dmem_responder.
// Latency : n/a (wiring only).
// Backpressure: the core holds req_valid until req_ready; stall_m freezes the pipeline meanwhile.
// Ports   : req_valid/req_write/req_funct3/req_addr/req_wdata (core -> responder),
//           req_ready/rsp_valid/rsp_rdata/rsp_err/stall_m (responder -> core).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall_m;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
    );
endinterface

// File: rtl/dmem_responder.sv
// Purpose : data-memory responder for the M stage; RISC-V byte/half/word loads and stores.
// Latency : response (rsp_valid pulse) WAIT_STATES+1 cycles after the acceptance edge.
// Backpressure: req_ready only in IDLE; stall_m holds the pipeline while an access is outstanding.
// Ports   : clk, reset (async active-low), bus (slave side of dmem_responder_if).
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        w_accept, w_commit;

    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    // FSM next-state
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        w_commit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        // zero wait states: the acceptance edge is also the commit edge
                        w_state_nxt    = ST_RESP;
                        w_commit       = 1'b1;
                        w_wait_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Commit operands: a commit from IDLE only happens with zero wait states,
    // where the request has not been latched yet, so take it straight off the bus.
    logic        w_c_write;
    logic [2:0]  w_c_funct3;
    logic [31:0] w_c_addr;
    logic [31:0] w_c_wdata;
    logic [1:0]  w_lane;
    logic [AW-1:0] w_idx;

    assign w_c_write  = (r_state == ST_IDLE) ? bus.req_write  : r_write;
    assign w_c_funct3 = (r_state == ST_IDLE) ? bus.req_funct3 : r_funct3;
    assign w_c_addr   = (r_state == ST_IDLE) ? bus.req_addr   : r_addr;
    assign w_c_wdata  = (r_state == ST_IDLE) ? bus.req_wdata  : r_wdata;
    assign w_lane     = w_c_addr[1:0];
    assign w_idx      = w_c_addr[AW+1:2];

    // Error decode: unsigned-load encodings are illegal for stores.
    logic w_legal, w_misal, w_range_err, w_err;
    always_comb begin
        w_legal = 1'b1;
        w_misal = 1'b0;
        case (w_c_funct3)
            3'b000:        w_misal = 1'b0;
            3'b001:        w_misal = w_c_addr[0];
            3'b010:        w_misal = (w_c_addr[1:0] != 2'b00);
            3'b100:        w_legal = !w_c_write;
            3'b101: begin
                w_legal = !w_c_write;
                w_misal = w_c_addr[0];
            end
            default:       w_legal = 1'b0;
        endcase
    end

    assign w_range_err = ({2'b00, w_c_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err       = !w_legal || w_misal || w_range_err;

    // Load formatting and store byte-lane merge
    logic [31:0] w_word, w_load_dat, w_wr_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_dat = 32'd0;
        case (w_c_funct3)
            3'b000:  w_load_dat = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_dat = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_dat = w_word;
            3'b100:  w_load_dat = {24'd0, w_byte};
            3'b101:  w_load_dat = {16'd0, w_half};
            default: w_load_dat = 32'd0;
        endcase
    end

    always_comb begin
        w_wr_word = w_word;
        case (w_c_funct3[1:0])
            2'b00:   w_wr_word[{w_lane, 3'b000} +: 8]     = w_c_wdata[7:0];
            2'b01:   w_wr_word[{w_lane[1], 4'b0000} +: 16] = w_c_wdata[15:0];
            2'b10:   w_wr_word = w_c_wdata;
            default: w_wr_word = w_word;
        endcase
    end

    // Request latch and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_c_write) ? 32'd0 : w_load_dat;
            end
        end
    end

    // Storage is not reset; gating on reset makes a reset coinciding with the
    // commit edge suppress the write.
    always_ff @(posedge clk) begin
        if (reset && w_commit && w_c_write && !w_err) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.stall_m   = ((r_state == ST_IDLE) && bus.req_valid) || (r_state == ST_WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Purpose : directed self-checking bench for dmem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder_if if2();
    dmem_responder_if if0();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut2 (.clk(clk), .reset(rst_n), .bus(if2));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (.clk(clk), .reset(rst_n), .bus(if0));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle_bus();
        if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_funct3 = 3'd0;
        if2.req_addr = 32'd0; if2.req_wdata = 32'd0;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_funct3 = 3'd0;
        if0.req_addr = 32'd0; if0.req_wdata = 32'd0;
    endtask

    // One access on the WAIT_STATES=2 instance, started at a negedge with the DUT idle.
    // Returns response fields, cycles from acceptance to rsp_valid, stall_m cycle count,
    // a timeout flag and rsp_valid one cycle after the response. Ends at a negedge in IDLE.
    task automatic access2(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                           output int lat, output int st, output logic to, output logic after);
        rd = 'x; er = 'x; lat = 0; to = 1'b1; after = 1'bx;
        if2.req_valid = 1'b1; if2.req_write = wr; if2.req_funct3 = f3;
        if2.req_addr = addr; if2.req_wdata = wdata;
        #1;
        st = (if2.stall_m === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        // scramble the request so any late sampling shows up as a wrong result
        if2.req_valid = 1'b0; if2.req_write = ~wr; if2.req_funct3 = 3'b011;
        if2.req_addr = ~addr; if2.req_wdata = ~wdata;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (if2.stall_m === 1'b1) st++;
            if (if2.rsp_valid === 1'b1) begin
                lat = c; rd = if2.rsp_rdata; er = if2.rsp_err; to = 1'b0;
                break;
            end
        end
        @(negedge clk);
        after = if2.rsp_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_bus();
        #12;
        n_tests++; if (if2.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", if2.req_ready); end
        n_tests++; if (if2.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", if2.rsp_valid); end
        n_tests++; if (if2.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", if2.rsp_rdata); end
        n_tests++; if (if2.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", if2.rsp_err); end
        n_tests++; if (if2.stall_m !== 1'b0) begin n_fail++; $display("FAIL reset_stall_low: got %b want 0", if2.stall_m); end
        n_tests++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_ws0: got %b want 1", if0.req_ready); end
        if2.req_valid = 1'b1;
        #1;
        n_tests++; if (if2.stall_m !== 1'b1) begin n_fail++; $display("FAIL reset_stall_follows: got %b want 1", if2.stall_m); end
        if2.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er, to, af; int lat, st;
        access2(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, st, to, af);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL sw_timeout: no response"); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
        n_tests++; if (st != 3) begin n_fail++; $display("FAIL sw_stall_cycles: got %0d want 3", st); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", er); end
        n_tests++; if (af !== 1'b0) begin n_fail++; $display("FAIL sw_single_pulse: got %b want 0", af); end
        access2(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_tests++; if (st != 3) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 3", st); end
        n_tests++; if (af !== 1'b0) begin n_fail++; $display("FAIL lw_single_pulse: got %b want 0", af); end
    endtask

    task automatic test_load_formats();
        logic [31:0] rd, a, e; logic [2:0] f; logic er, to, af; int lat, st;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin f = 3'b000; a = 32'h13; e = 32'hFFFFFFDE; end
                1:       begin f = 3'b100; a = 32'h13; e = 32'h000000DE; end
                2:       begin f = 3'b001; a = 32'h10; e = 32'hFFFFBEEF; end
                default: begin f = 3'b101; a = 32'h12; e = 32'h0000DEAD; end
            endcase
            access2(1'b0, f, a, 32'h0, rd, er, lat, st, to, af);
            n_tests++; if (rd !== e) begin n_fail++; $display("FAIL load_fmt[%0d]: got %h want %h", i, rd, e); end
            n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL load_fmt_err[%0d]: got %b want 0", i, er); end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic er, to, af; int lat, st;
        access2(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, rd, er, lat, st, to, af);
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", er); end
        access2(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_merge: got %h want dead55ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, to, af; int lat, st;
        access2(1'b1, 3'b010, 32'h20, 32'h01020304, rd, er, lat, st, to, af);
        access2(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL err_setup: got %h want 01020304", rd); end
        access2(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL lw_misaligned_err: got %b want 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL lw_misaligned_data: got %h want 0", rd); end
        access2(1'b1, 3'b001, 32'h21, 32'h0000FFFF, rd, er, lat, st, to, af);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL sh_misaligned_err: got %b want 1", er); end
        access2(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL sh_no_write: got %h want 01020304", rd); end
        access2(1'b0, 3'b010, 32'h400, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL range_err: got %b want 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL range_data: got %h want 0", rd); end
        access2(1'b0, 3'b011, 32'h20, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL funct3_err: got %b want 1", er); end
    endtask

    // WAIT_STATES=0, req_valid held high across four accesses.
    task automatic test_back_to_back();
        logic [31:0] ad [4];
        logic [31:0] wd [4];
        logic        wr [4];
        ad[0] = 32'h8; wd[0] = 32'hA5A5A5A5; wr[0] = 1'b1;
        ad[1] = 32'hC; wd[1] = 32'h0BADF00D; wr[1] = 1'b1;
        ad[2] = 32'h8; wd[2] = 32'h0;        wr[2] = 1'b0;
        ad[3] = 32'hC; wd[3] = 32'h0;        wr[3] = 1'b0;
        if0.req_valid = 1'b1; if0.req_funct3 = 3'b010;
        if0.req_write = wr[0]; if0.req_addr = ad[0]; if0.req_wdata = wd[0];
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (if0.req_ready !== 1'b1 || if0.stall_m !== 1'b1 || if0.rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_idle[%0d]: ready/stall/valid got %b%b%b want 110", i, if0.req_ready, if0.stall_m, if0.rsp_valid); end
            @(negedge clk);
            n_tests++; if (if0.rsp_valid !== 1'b1 || if0.req_ready !== 1'b0 || if0.stall_m !== 1'b0) begin
                n_fail++; $display("FAIL b2b_resp[%0d]: valid/ready/stall got %b%b%b want 100", i, if0.rsp_valid, if0.req_ready, if0.stall_m); end
            if (!wr[i]) begin
                n_tests++; if (if0.rsp_rdata !== wd[i-2]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, if0.rsp_rdata, wd[i-2]); end
            end
            if (i < 3) begin
                if0.req_write = wr[i+1]; if0.req_addr = ad[i+1]; if0.req_wdata = wd[i+1];
            end else begin
                if0.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++; if (if0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", if0.rsp_valid); end
        n_tests++; if (if0.rsp_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_hold: got %h want 0badf00d", if0.rsp_rdata); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er, to, af, seen; int lat, st;
        access2(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, rd, er, lat, st, to, af);
        access2(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, st, to, af);
        if2.req_valid = 1'b1; if2.req_write = 1'b1; if2.req_funct3 = 3'b010;
        if2.req_addr = 32'h40; if2.req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        if2.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (if2.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready: got %b want 1", if2.req_ready); end
        n_tests++; if (if2.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_wait_rdata: got %h want 0", if2.rsp_rdata); end
        n_tests++; if (if2.stall_m !== 1'b0) begin n_fail++; $display("FAIL rst_wait_stall: got %b want 0", if2.stall_m); end
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (if2.rsp_valid === 1'b1) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if2.rsp_valid === 1'b1) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_rsp: got %b want 0", seen); end
        access2(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, st, to, af);
        n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_wait_no_write: got %h want cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_load_formats();
        test_byte_store();
        test_errors();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
